// File: rtl/cva6_pma_table.sv
// Runtime-programmable PMA table with a one-stage lookup pipeline.
// Define CVA6_PMA_LOCK_EN to make attr bit 3 a sticky per-rule write lock.
module cva6_pma_table #(
  parameter int unsigned NrRules   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRules*AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules*AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules*4-1:0]         RstAttr   = '0,
  localparam int unsigned IdxW =
    (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [IdxW-1:0]      resp_idx_o,
  output logic                 resp_cached_o,
  output logic                 resp_exec_o,
  output logic                 resp_nonidem_o
);

`ifdef CVA6_PMA_LOCK_EN
  localparam logic [3:0] AttrMask = 4'hF;
`else
  localparam logic [3:0] AttrMask = 4'h7;
`endif

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [3:0]           attr_q [NrRules];

  logic                 idx_ok;
  logic                 locked;
  logic                 wr_ok;
  logic [AddrWidth-1:0] rd_d;
  logic [AddrWidth-1:0] rdata_q;
  logic                 err_q;

  assign idx_ok = 32'(cfg_idx_i) < NrRules;

`ifdef CVA6_PMA_LOCK_EN
  always_comb begin
    locked = 1'b0;
    if (idx_ok) locked = attr_q[cfg_idx_i][3];
  end
`else
  assign locked = 1'b0;
`endif

  assign wr_ok = idx_ok && (cfg_field_i != 2'd3) && !locked;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
        len_q[i]  <= RstLength[i*AddrWidth +: AddrWidth];
        attr_q[i] <= RstAttr[i*4 +: 4] & AttrMask;
      end
    end else if (cfg_we_i && wr_ok) begin
      unique case (cfg_field_i)
        2'd0:    base_q[cfg_idx_i] <= cfg_wdata_i;
        2'd1:    len_q[cfg_idx_i]  <= cfg_wdata_i;
        2'd2:    attr_q[cfg_idx_i] <= cfg_wdata_i[3:0] & AttrMask;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    if (idx_ok) begin
      unique case (cfg_field_i)
        2'd0:    rd_d = base_q[cfg_idx_i];
        2'd1:    rd_d = len_q[cfg_idx_i];
        2'd2:    rd_d = AddrWidth'(attr_q[cfg_idx_i]);
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rd_d;
      err_q   <= cfg_we_i && !wr_ok;
    end
  end

  assign cfg_rdata_o = rdata_q;
  assign cfg_err_o   = err_q;

  // Region end is one bit wider so a rule may reach the top of space.
  logic [AddrWidth:0] end_v;
  logic               hit_d;
  logic [IdxW-1:0]    win_d;
  logic [3:0]         attr_d;

  always_comb begin
    end_v = '0;
    hit_d = 1'b0;
    win_d = '0;
    for (int i = int'(NrRules) - 1; i >= 0; i--) begin
      end_v = {1'b0, base_q[i]} + {1'b0, len_q[i]};
      if ((len_q[i] != '0) &&
          (req_addr_i >= base_q[i]) &&
          ({1'b0, req_addr_i} < end_v)) begin
        hit_d = 1'b1;
        win_d = i[IdxW-1:0];
      end
    end
  end

  assign attr_d = hit_d ? attr_q[win_d] : 4'h0;

  logic            v_q;
  logic            hit_q;
  logic [IdxW-1:0] idx_q;
  logic            cached_q;
  logic            exec_q;
  logic            nonidem_q;
  logic            fire;

  assign req_ready_o = !v_q || resp_ready_i;
  assign fire        = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q       <= 1'b0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      cached_q  <= 1'b0;
      exec_q    <= 1'b0;
      nonidem_q <= 1'b0;
    end else if (fire) begin
      v_q       <= 1'b1;
      hit_q     <= hit_d;
      idx_q     <= win_d;
      cached_q  <= attr_d[0];
      exec_q    <= attr_d[1];
      nonidem_q <= hit_d ? attr_d[2] : 1'b1;
    end else if (resp_ready_i) begin
      v_q <= 1'b0;
    end
  end

  assign resp_valid_o   = v_q;
  assign resp_hit_o     = hit_q;
  assign resp_idx_o     = idx_q;
  assign resp_cached_o  = cached_q;
  assign resp_exec_o    = exec_q;
  assign resp_nonidem_o = nonidem_q;

endmodule

// File: tb/tb_cva6_pma_table.sv
// Scoreboard bench for cva6_pma_table (4 rules, 64-bit addresses).
// Lock expectations follow CVA6_PMA_LOCK_EN.
module tb_cva6_pma_table;

  localparam logic [4*64-1:0] RST_BASE =
    {64'h0, 64'h0, 64'h0, 64'h8000_0000};
  localparam logic [4*64-1:0] RST_LEN =
    {64'h0, 64'h0, 64'h0, 64'h4000_0000};
  localparam logic [15:0] RST_ATTR = 16'h0003;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
    logic       c;
    logic       e;
    logic       n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [1:0]  cfg_field;
  logic [63:0] cfg_wdata;
  logic [63:0] cfg_rdata;
  logic        cfg_err;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [1:0]  resp_idx;
  logic        resp_cached;
  logic        resp_exec;
  logic        resp_nonidem;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  cva6_pma_table #(
    .NrRules  (4),
    .AddrWidth(64),
    .RstBase  (RST_BASE),
    .RstLength(RST_LEN),
    .RstAttr  (RST_ATTR)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg_we_i      (cfg_we),
    .cfg_idx_i     (cfg_idx),
    .cfg_field_i   (cfg_field),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_rdata_o   (cfg_rdata),
    .cfg_err_o     (cfg_err),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_hit_o    (resp_hit),
    .resp_idx_o    (resp_idx),
    .resp_cached_o (resp_cached),
    .resp_exec_o   (resp_exec),
    .resp_nonidem_o(resp_nonidem)
  );

  always #5 clk = ~clk;

  // Response monitor: compare on every completed handshake.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      exp_t got;
      got = {resp_hit, resp_idx, resp_cached,
             resp_exec, resp_nonidem};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp got=%b", got);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL resp got=%b want=%b (hit,idx,c,e,n)",
                   got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cfg_write(input logic [1:0] i,
                           input logic [1:0] f,
                           input logic [63:0] d,
                           input logic exp_err);
    cfg_we = 1'b1;
    cfg_idx = i;
    cfg_field = f;
    cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    total++;
    if (cfg_err !== exp_err) begin
      bad++;
      $display("FAIL cfg_err idx=%0d fld=%0d got=%b want=%b",
               i, f, cfg_err, exp_err);
    end
  endtask

  task automatic cfg_read(input logic [1:0] i,
                          input logic [1:0] f,
                          input logic [63:0] exp_d);
    cfg_idx = i;
    cfg_field = f;
    @(posedge clk); #1;
    total++;
    if (cfg_rdata !== exp_d) begin
      bad++;
      $display("FAIL rdata idx=%0d fld=%0d got=%h want=%h",
               i, f, cfg_rdata, exp_d);
    end
  endtask

  task automatic lookup(input logic [63:0] a,
                        input logic h,
                        input logic [1:0] ix,
                        input logic c,
                        input logic e,
                        input logic n);
    int k;
    exp_q.push_back(exp_t'{h, ix, c, e, n});
    req_valid = 1'b1;
    req_addr = a;
    for (k = 0; k < 20 && !req_ready; k++) begin
      @(posedge clk); #1;
    end
    if (k == 20) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 50 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout left=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    total++;
    if ({resp_valid, resp_hit, resp_idx, resp_cached,
         resp_exec, resp_nonidem, cfg_err} !== 8'h00) begin
      bad++;
      $display("FAIL reset_resp got=%b want=0",
               {resp_valid, resp_hit, resp_idx, resp_cached,
                resp_exec, resp_nonidem, cfg_err});
    end
    total++;
    if (cfg_rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata got=%h want=0", cfg_rdata);
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_defaults();
    cfg_read(0, 0, 64'h8000_0000);
    cfg_read(0, 1, 64'h4000_0000);
    cfg_read(0, 2, 64'h3);
    lookup(64'h8000_1000, 1, 0, 1, 1, 0);
    total++;
    if (resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency resp_valid got=%b want=1",
               resp_valid);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [4];
    exp_t        exps  [4];
    addrs = '{64'hFFFF, 64'h1_0000, 64'h1_FFFF, 64'h2_0000};
    exps  = '{exp_t'{0, 0, 0, 0, 1}, exp_t'{1, 1, 1, 0, 0},
              exp_t'{1, 1, 1, 0, 0}, exp_t'{0, 0, 0, 0, 1}};
    cfg_write(1, 0, 64'h1_0000, 0);
    cfg_write(1, 1, 64'h1_0000, 0);
    cfg_write(1, 2, 64'h1, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (req_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready i=%0d got=%b want=1",
                 i, req_ready);
      end
      lookup(addrs[i], exps[i].hit, exps[i].idx,
             exps[i].c, exps[i].e, exps[i].n);
    end
    drain();
  endtask

  task automatic test_priority();
    cfg_write(3, 0, 64'h4000, 0);
    cfg_write(3, 1, 64'h2000, 0);
    cfg_write(3, 2, 64'h2, 0);
    cfg_write(1, 0, 64'h5000, 0);
    cfg_write(1, 1, 64'h1000, 0);
    cfg_write(1, 2, 64'h1, 0);
    lookup(64'h5000, 1, 1, 1, 0, 0);
    cfg_write(1, 1, 64'h0, 0);
    lookup(64'h5000, 1, 3, 0, 1, 0);
    drain();
  endtask

  task automatic test_top_of_space();
    cfg_write(2, 0, 64'hFFFF_FFFF_FFFF_F000, 0);
    cfg_write(2, 1, 64'h1000, 0);
    cfg_write(2, 2, 64'h4, 0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 0, 0, 1);
    lookup(64'h0, 0, 0, 0, 0, 1);
    lookup(64'hFFFF_FFFF_FFFF_EFFF, 0, 0, 0, 0, 1);
    drain();
  endtask

  task automatic test_invalid();
    cfg_write(0, 3, 64'h55, 1);
    @(posedge clk); #1;
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse_width got=%b want=0", cfg_err);
    end
    cfg_read(0, 3, 64'h0);
    cfg_read(0, 0, 64'h8000_0000);
  endtask

  task automatic test_lock();
    cfg_write(2, 2, 64'h8, 0);
`ifdef CVA6_PMA_LOCK_EN
    cfg_write(2, 0, 64'h1234, 1);
    cfg_read(2, 0, 64'hFFFF_FFFF_FFFF_F000);
    cfg_read(2, 2, 64'h8);
    cfg_write(2, 2, 64'h0, 1);
    cfg_read(2, 2, 64'h8);
`else
    cfg_write(2, 0, 64'h1234, 0);
    cfg_read(2, 0, 64'h1234);
    cfg_read(2, 2, 64'h0);
`endif
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    exp_q.push_back(exp_t'{1, 3, 0, 1, 0});
    req_valid = 1'b1;
    req_addr = 64'h4100;
    @(posedge clk); #1;
    req_addr = 64'h4200;
    cfg_we = 1'b1;
    cfg_idx = 2'd3;
    cfg_field = 2'd2;
    cfg_wdata = 64'h5;
    exp_q.push_back(exp_t'{1, 3, 1, 0, 1});
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({req_ready, resp_valid, resp_cached, resp_exec,
           resp_nonidem} !== 5'b01010) begin
        bad++;
        $display("FAIL stall k=%0d got=%b want=01010", k,
                 {req_ready, resp_valid, resp_cached,
                  resp_exec, resp_nonidem});
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_same_cycle_write();
    cfg_we = 1'b1;
    cfg_idx = 2'd3;
    cfg_field = 2'd2;
    cfg_wdata = 64'h3;
    req_valid = 1'b1;
    req_addr = 64'h4100;
    exp_q.push_back(exp_t'{1, 3, 1, 0, 1});
    @(posedge clk); #1;
    cfg_we = 1'b0;
    exp_q.push_back(exp_t'{1, 3, 1, 1, 0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 64'h4100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL held_before_rst got=%b want=1", resp_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got=%b want=0", resp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL ghost_resp k=%0d got=%b want=0",
                 k, resp_valid);
      end
    end
    cfg_read(3, 1, 64'h0);
    cfg_write(2, 0, 64'h1234, 0);
    lookup(64'h8000_1000, 1, 0, 1, 1, 0);
    lookup(64'h4100, 0, 0, 0, 0, 1);
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_field = '0;
    cfg_wdata = '0;
    req_valid = 1'b0;
    req_addr = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_defaults();
    test_back_to_back();
    test_priority();
    test_top_of_space();
    test_invalid();
    test_lock();
    test_backpressure();
    test_same_cycle_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cva6_pma_table.md
# cva6_pma_table

Runtime-programmable physical-memory-attribute table, the parametrised successor to the static cached/execute/non-idempotent region rules fixed in the CVA6 config package. It holds NrRules address regions with per-rule attributes, programmable through a register-style write port. It answers pipelined address lookups with a valid/ready handshake. It sits between the MMU/PMP path and the cache controllers, replacing compile-time region constants.

## Interface
- NrRules, default 4: number of region rules (1..16).
- AddrWidth, default 64: physical address width.
- RstBase, default all-zero: packed NrRules×AddrWidth reset base values; rule i in slice i.
- RstLength, default all-zero: packed NrRules×AddrWidth reset lengths; 0 disables the rule.
- RstAttr, default all-zero: packed NrRules×4 reset attributes {lock, nonidem, exec, cached}.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_we_i  in  1  write strobe, single-cycle, always accepted.
- cfg_idx_i  in  $clog2(NrRules)  rule index; values ≥ NrRules are invalid.
- cfg_field_i  in  2  0=base, 1=length, 2=attr, 3=reserved.
- cfg_wdata_i  in  AddrWidth  write data; attr uses bits [3:0].
- cfg_rdata_o  out  AddrWidth  registered readback of {cfg_idx_i, cfg_field_i}.
- cfg_err_o  out  1  one-cycle pulse on a rejected write.
- req_valid_i / req_ready_o  in/out  1  lookup handshake.
- req_addr_i  in  AddrWidth  lookup address.
- resp_valid_o / resp_ready_i  out/in  1  result handshake.
- resp_hit_o  out  1  some enabled rule matched.
- resp_idx_o  out  $clog2(NrRules)  winning rule index; 0 on miss.
- resp_cached_o, resp_exec_o, resp_nonidem_o  out  1 each  attributes of the winning rule.

## Operation
- Rule i matches when length≠0 and base ≤ addr < base+length. The sum is computed in AddrWidth+1 bits, so a region ending at 2^AddrWidth is legal and never wraps.
- Priority: lowest matching index wins.
- Miss response: hit=0, idx=0, cached=0, exec=0, nonidem=1 (conservative).
- Write: field 3, or an index ≥ NrRules, is rejected. The table is unchanged and cfg_err_o pulses the next cycle.
- Lock (see Configuration): when attr.lock=1 for rule i, all writes to rule i are rejected with cfg_err_o. Lock clears only on reset.
- Readback: cfg_rdata_o updates every cycle with the addressed field. Attr reads are zero-extended. Invalid selections read 0.
- Lookup pipeline: one output register stage. req_ready_o = !resp_valid_o || resp_ready_i.

## Timing
- Reset: table loads RstBase/RstLength/RstAttr. resp_valid_o=0, resp_hit_o=0, resp_idx_o=0, attribute outputs 0, cfg_rdata_o=0, cfg_err_o=0.
- Lookup latency is 1 cycle. A request accepted in cycle N produces resp_valid_o=1 in N+1, held stable until resp_ready_i.
- Back-to-back throughput is 1/cycle while resp_ready_i=1.
- Write takes effect at the next edge. A lookup accepted in the same cycle as a write sees pre-write values. A lookup accepted in the following cycle sees the new values.
- Stalled response: output holds its captured attributes; later table writes do not alter it.
- Reset mid-operation discards any held response; no response emerges after reset.
- cfg_rdata_o reflects the table state at the preceding edge, with one cycle read latency.

## Configuration
- CVA6_PMA_LOCK_EN defined: attr bit 3 is storable and enforced as above.
- CVA6_PMA_LOCK_EN undefined: the lock bit is tied 0 (reads 0, ignores writes and RstAttr[3]). Only invalid field/index writes raise cfg_err_o.

## Test plan
- Reset defaults (NrRules=4, rule0 base 0x8000_0000 len 0x4000_0000 attr cached|exec): lookup 0x8000_1000 -> next cycle hit=1, idx=0, cached=1, exec=1, nonidem=0.
- Boundary: rule1 base 0x1_0000 len 0x1_0000. Lookups at 0xFFFF, 0x1_0000, 0x1_FFFF, 0x2_0000 -> miss, hit, hit, miss. Miss responses carry nonidem=1.
- Overlap priority: rules 1 and 3 both cover 0x5000 -> idx=1. Set rule1 len=0 -> idx=3.
- Top-of-space: base 2^64−0x1000, len 0x1000. Addr 2^64−1 -> hit. Addr 0 -> miss (no wrap).
- Lock (macro on): write attr of rule2 = 0x8, then write base of rule2 -> cfg_err_o=1 for one cycle, readback unchanged. Macro off: same write succeeds, attr readback 0x0.
- Backpressure plus same-cycle write: hold resp_ready_i=0 for 3 cycles while rewriting the matching rule's attr. The held response keeps the old attributes and req_ready_o=0 for the whole stall. The next lookup returns the new attributes.
